shift_seq: RTL and testbench
============================

// Module: shift_seq
// PURPOSE
//  Multi-cycle shift sequencer that drives a single-bit shifter stage to
//  produce an N-bit shift, one bit position per clock.
//  Accepts {operand, amount, mode} over a valid/ready handshake, iterates,
//  then presents the result and the last shifted-out bit on an output
//  valid/ready handshake.
//  Sits between the ALU operand/decode stage and the result mux.
// PARAMETERS
//  WIDTH  4  operand/result width in bits
//  AMT_W  2  shift-amount width; amounts 0..2^AMT_W-1 are legal
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      request valid
//  in_ready   out  1      sequencer can accept a request (state IDLE)
//  a          in   WIDTH  operand
//  amt        in   AMT_W  shift amount
//  mode       in   2      00 logical left, 01 logical right,
//                         10 arithmetic right, 11 rotate left
//  out_valid  out  1      y/carry valid (state DONE)
//  out_ready  in   1      consumer accepts result
//  y          out  WIDTH  shifted result
//  carry      out  1      last bit shifted or rotated out; 0 when amt==0
//  busy       out  1      1 in SHIFT or DONE
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; data reg, count, mode reg, carry all 0
//   - y=0, out_valid=0, busy=0, in_ready=1 once rst deasserts
//  FSM states are IDLE, SHIFT and DONE.
//   - IDLE: in_ready=1. On edge with in_valid: capture a->data, amt->count,
//     mode->mode reg, carry<=0. Next state is DONE if amt==0, else SHIFT.
//   - SHIFT: each edge shifts data by 1 per the captured mode, sets
//     carry<=bit leaving the word, count<=count-1.
//     When count==1 on that edge, next state is DONE.
//   - DONE: out_valid=1, y=data. Edge with out_ready moves to IDLE.
//     Otherwise state holds and y/carry stay stable.
//  Shift rules, one step:
//   - LL: {d[W-2:0],0}, carry=d[W-1]
//   - LR: {0,d[W-1:1]}, carry=d[0]
//   - AR: {d[W-1],d[W-1:1]}, carry=d[0]
//   - RL: {d[W-2:0],d[W-1]}, carry=d[W-1]
//  Timing:
//   - Latency: request accepted on edge k -> out_valid high from edge k+amt,
//     with amt==0 counting as edge k.
//   - Back-to-back: with out_ready held 1, the next request is accepted no
//     earlier than 1 cycle after leaving DONE. There is no IDLE bypass.
//   - Throughput: one request per amt+2 cycles.
//  Boundary cases:
//   - in_valid while not IDLE: ignored, since in_ready=0. Inputs are
//     sampled only at capture; later changes to a/amt/mode have no effect.
//   - amt >= WIDTH: still shifted bit-by-bit. LL/LR give 0, AR gives all
//     sign bits, RL wraps modulo WIDTH.
//   - out_valid never drops without out_ready. y is only meaningful while
//     out_valid=1, but it holds data in IDLE.
//   - rst asserted mid-SHIFT or in DONE: immediate abort to reset values.
//     The in-flight result is discarded and no out_valid pulse occurs.
// TESTING (WIDTH=4, AMT_W=2)
//  1. a=0101, amt=1, mode=LL -> out_valid after 1 edge; y=1010, carry=0.
//  2. a=0101, amt=2, mode=LR -> y=0001, carry=0.
//     a=1010, amt=2, mode=AR -> y=1110, carry=1. Both: out_valid 2 edges
//     after accept.
//  3. a=0101, amt=2, mode=RL -> y=0101, carry=1.
//     a=1001, amt=0, any mode -> y=1001, carry=0, out_valid on accept edge.
//  4. Backpressure: hold out_ready=0 for 5 cycles while driving
//     in_valid=1, a=1111 -> y/carry/out_valid stable, in_ready=0, new
//     request ignored. Raise out_ready -> IDLE, then 1111 accepted.
//  5. Assert rst during SHIFT (amt=3, after 1 step), asynchronously between
//     edges -> y=0, out_valid=0, busy=0 immediately. After release, a fresh
//     request completes correctly.
//  6. Random a/amt/mode against a reference model, with random in_valid and
//     out_ready -> every accepted request yields exactly one matching
//     result, in order.

Source files
------------

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: accepts {operand, amount, mode}, walks a
// single-bit shifter stage once per clock, then presents the result.
module shift_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LL = 2'b00;
  localparam logic [1:0] MODE_LR = 2'b01;
  localparam logic [1:0] MODE_AR = 2'b10;
  localparam logic [1:0] MODE_RL = 2'b11;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data;
  logic [AMT_W-1:0] count;
  logic [1:0]       mode_r;
  logic             carry_r;
  logic [WIDTH-1:0] step_data;
  logic             step_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // One-position shifter stage driven by the mode captured at accept time
  always_comb begin
    step_data = data;
    step_out  = 1'b0;
    case (mode_r)
      MODE_LL: begin
        step_data = {data[WIDTH-2:0], 1'b0};
        step_out  = data[WIDTH-1];
      end
      MODE_LR: begin
        step_data = {1'b0, data[WIDTH-1:1]};
        step_out  = data[0];
      end
      MODE_AR: begin
        step_data = {data[WIDTH-1], data[WIDTH-1:1]};
        step_out  = data[0];
      end
      MODE_RL: begin
        step_data = {data[WIDTH-2:0], data[WIDTH-1]};
        step_out  = data[WIDTH-1];
      end
      default: begin
        step_data = data;
        step_out  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      count   <= '0;
      mode_r  <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data    <= a;
            count   <= amt;
            mode_r  <= mode;
            carry_r <= 1'b0;
          end
        end
        SHIFT: begin
          data    <= step_data;
          carry_r <= step_out;
          count   <= count - AMT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // y keeps showing the data register in IDLE as well as DONE
  assign y     = data;
  assign carry = carry_r;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed vector table, backpressure,
// asynchronous abort, and a randomized run against a reference model.
module tb_shift_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [1:0] amt;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
  logic       carry;
  logic       busy;

  int vectors;
  int errors;

  typedef struct {
    logic [3:0] a;
    logic [1:0] amt;
    logic [1:0] mode;
    logic [3:0] exp_y;
    logic       exp_c;
  } vec_t;

  vec_t vecs[10];

  shift_seq #(.WIDTH(4), .AMT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: walks the shift one position at a time, returns {carry, y}
  function automatic logic [4:0] refShift(input logic [3:0] d_in, input logic [1:0] n,
                                          input logic [1:0] m);
    logic [3:0] d;
    logic       c;
    d = d_in;
    c = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      case (m)
        2'b00: begin c = d[3]; d = d << 1; end
        2'b01: begin c = d[0]; d = d >> 1; end
        2'b10: begin c = d[0]; d = {d[3], d[3:1]}; end
        default: begin c = d[3]; d = {d[2:0], d[3]}; end
      endcase
    end
    return {c, d};
  endfunction

  // One full transaction: accept, measure latency, check result, drain
  task automatic applyStimulus(input string name, input logic [3:0] va, input logic [1:0] vamt,
                               input logic [1:0] vmode, input logic [3:0] ey, input logic ec);
    int cycles;
    @(negedge clk);
    checkOutput({name, ".in_ready"}, 32'(in_ready), 32'd1);
    a         = va;
    amt       = vamt;
    mode      = vmode;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~va;
    amt      = ~vamt;
    cycles   = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({name, ".latency"}, 32'(cycles), 32'(vamt));
    checkOutput({name, ".y"}, 32'(y), 32'(ey));
    checkOutput({name, ".carry"}, 32'(carry), 32'(ec));
    checkOutput({name, ".busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({name, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  logic [3:0] r_a;
  logic [1:0] r_amt;
  logic [1:0] r_mode;
  logic [4:0] exp_q[$];
  logic [4:0] exp_r;
  logic       acc;
  logic       fire;
  logic [3:0] got_y;
  logic       got_c;

  initial begin
    vectors = 0;
    errors  = 0;
    //               a        amt    mode   exp_y    exp_c
    vecs[0] = '{4'b0101, 2'd1, 2'b00, 4'b1010, 1'b0};
    vecs[1] = '{4'b0101, 2'd2, 2'b01, 4'b0001, 1'b0};
    vecs[2] = '{4'b1010, 2'd2, 2'b10, 4'b1110, 1'b1};
    vecs[3] = '{4'b0101, 2'd2, 2'b11, 4'b0101, 1'b1};
    vecs[4] = '{4'b1001, 2'd0, 2'b10, 4'b1001, 1'b0};
    vecs[5] = '{4'b1101, 2'd3, 2'b00, 4'b1000, 1'b0};
    vecs[6] = '{4'b0110, 2'd3, 2'b10, 4'b0000, 1'b1};
    vecs[7] = '{4'b1000, 2'd3, 2'b11, 4'b0100, 1'b0};
    vecs[8] = '{4'b1011, 2'd1, 2'b01, 4'b0101, 1'b1};
    vecs[9] = '{4'b1000, 2'd3, 2'b10, 4'b1111, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    amt       = '0;
    mode      = '0;
    #12;
    rst = 1'b0;
    #1;
    checkOutput("reset.y", 32'(y), 32'd0);
    checkOutput("reset.carry", 32'(carry), 32'd0);
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].amt, vecs[i].mode,
                    vecs[i].exp_y, vecs[i].exp_c);
    end

    // Backpressure: result must hold while a new request is being offered
    @(negedge clk);
    a = 4'b0101; amt = 2'd1; mode = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    a = 4'b1111;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp.y", 32'(y), 32'b1010);
      checkOutput("bp.carry", 32'(carry), 32'd0);
      checkOutput("bp.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp.release_idle", 32'(in_ready), 32'd1);
    checkOutput("bp.release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp.accept_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp.new_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp.new_y", 32'(y), 32'b1110);
    checkOutput("bp.new_carry", 32'(carry), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous abort one step into a three-step shift
    @(negedge clk);
    a = 4'b1111; amt = 2'd3; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("abort.pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort.y", 32'(y), 32'd0);
    checkOutput("abort.out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort.no_pulse", 32'(out_valid), 32'd0);
    end
    applyStimulus("after_abort", 4'b0011, 2'd2, 2'b11, 4'b1100, 1'b0);

    // Randomized traffic against the reference model, in-order scoreboard
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      r_a       = 4'($urandom);
      r_amt     = 2'($urandom);
      r_mode    = 2'($urandom);
      a         = r_a;
      amt       = r_amt;
      mode      = r_mode;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      #4;
      acc   = in_valid && in_ready;
      fire  = out_valid && out_ready;
      got_y = y;
      got_c = carry;
      if (acc) exp_q.push_back(refShift(r_a, r_amt, r_mode));
      if (fire) begin
        if (exp_q.size() == 0) begin
          checkOutput("rand.unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_r = exp_q.pop_front();
          checkOutput("rand.y", 32'(got_y), 32'(exp_r[3:0]));
          checkOutput("rand.carry", 32'(got_c), 32'(exp_r[4]));
        end
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      #4;
      if (out_valid) begin
        exp_r = exp_q.pop_front();
        checkOutput("drain.y", 32'(y), 32'(exp_r[3:0]));
        checkOutput("drain.carry", 32'(carry), 32'(exp_r[4]));
      end
      @(negedge clk);
    end
    checkOutput("rand.pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
